// File: rtl/piso_4bit.sv
// Parallel-in / serial-out shift register: Load captures Data_In, otherwise the
// register shifts toward the output end and back-fills with FILL.
module piso_4bit #(
    parameter int   WIDTH     = 4,
    parameter int   MSB_FIRST = 1,
    parameter logic FILL      = 1'b0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_In,
    output logic             SO
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_shifted;
    logic             w_so;

    // Output end and shift direction are fixed at elaboration, so SO depends on r_sr alone.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_sr[WIDTH-2:0], FILL};
            assign w_so      = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {FILL, r_sr[WIDTH-1:1]};
            assign w_so      = r_sr[0];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_sr <= '0;
        end else if (Load) begin
            r_sr <= Data_In;
        end else begin
            r_sr <= w_shifted;
        end
    end

    assign SO = w_so;

endmodule

// File: tb/tb_piso_4bit.sv
// Directed bench for piso_4bit: one MSB-first and one LSB-first instance,
// clock period 100, outputs sampled 10 time units after each rising edge.
module tb_piso_4bit;

    logic       clock;
    logic       clear;
    logic       load_m;
    logic [3:0] din_m;
    logic       so_m;
    logic       load_l;
    logic [3:0] din_l;
    logic       so_l;

    int vectors;
    int miscompares;

    piso_4bit #(.WIDTH(4), .MSB_FIRST(1), .FILL(1'b0)) u_msb (
        .Clock   (clock),
        .Clear   (clear),
        .Load    (load_m),
        .Data_In (din_m),
        .SO      (so_m)
    );

    piso_4bit #(.WIDTH(4), .MSB_FIRST(0), .FILL(1'b0)) u_lsb (
        .Clock   (clock),
        .Clear   (clear),
        .Load    (load_l),
        .Data_In (din_l),
        .SO      (so_l)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #10;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [5:0] exp_seq;

        vectors     = 0;
        miscompares = 0;
        clear  = 1'b0;
        load_m = 1'b1;
        din_m  = 4'b1001;
        load_l = 1'b0;
        din_l  = 4'b0000;
        #1;
        check("reset_so_msb", so_m, 1'b0);
        check("reset_so_lsb", so_l, 1'b0);

        // Clear held low ignores Load across several edges
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("clear_hold_%0d", i), so_m, 1'b0);
        end

        // Load 1001 then shift out: 1,0,0,1 then fill zeros
        clear = 1'b1;
        step();
        check("load_1001", so_m, 1'b1);
        load_m  = 1'b0;
        exp_seq = 6'b001000;
        for (int i = 5; i >= 0; i--) begin
            step();
            check($sformatf("shift_1001_%0d", 5 - i), so_m, exp_seq[i]);
        end

        // Asynchronous clear from a loaded state, mid-cycle
        load_m = 1'b1;
        din_m  = 4'b1111;
        step();
        check("load_1111_pre_clear", so_m, 1'b1);
        #20;
        clear = 1'b0;
        #1;
        check("async_clear_so", so_m, 1'b0);
        step();
        check("clear_blocks_load", so_m, 1'b0);
        clear = 1'b1;

        // Load held high tracks Data_In[3], one edge delayed
        din_m = 4'b0001;
        step();
        check("hold_load_0001_a", so_m, 1'b0);
        step();
        check("hold_load_0001_b", so_m, 1'b0);
        din_m = 4'b1000;
        check("hold_load_no_comb_path", so_m, 1'b0);
        step();
        check("hold_load_1000", so_m, 1'b1);

        // Load 1011, one shift, reload 0110 on the third edge, then shift out
        din_m = 4'b1011;
        step();
        check("load_1011", so_m, 1'b1);
        load_m = 1'b0;
        step();
        check("shift_1011_0", so_m, 1'b0);
        load_m = 1'b1;
        din_m  = 4'b0110;
        step();
        check("reload_0110", so_m, 1'b0);
        load_m  = 1'b0;
        exp_seq = 6'b110000;
        for (int i = 5; i >= 1; i--) begin
            step();
            check($sformatf("shift_0110_%0d", 5 - i), so_m, exp_seq[i]);
        end

        // Data_In churn while shifting has no effect
        load_m = 1'b1;
        din_m  = 4'b1111;
        step();
        check("load_1111", so_m, 1'b1);
        load_m  = 1'b0;
        exp_seq = 6'b111000;
        for (int i = 5; i >= 1; i--) begin
            din_m = 4'($urandom_range(0, 15));
            step();
            check($sformatf("shift_1111_rand_%0d", 5 - i), so_m, exp_seq[i]);
        end

        // LSB-first: 1101 leaves as 1,0,1,1 then zeros
        load_l = 1'b1;
        din_l  = 4'b1101;
        step();
        check("lsb_load_1101", so_l, 1'b1);
        load_l  = 1'b0;
        exp_seq = 6'b011000;
        for (int i = 5; i >= 1; i--) begin
            din_l = 4'($urandom_range(0, 15));
            step();
            check($sformatf("lsb_shift_1101_%0d", 5 - i), so_l, exp_seq[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
